// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table and sizing/polarity helpers for the seven-segment scan driver.
// Contents: GLYPHS (16 active-high glyphs, bit order g..a), clog2_min1 (width helper, never 0),
// apply_pol (optional bitwise inversion applied as the last output stage).
package seg_pkg;
    localparam logic [6:0] GLYPHS [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    function automatic logic [7:0] apply_pol(input logic [7:0] v, input logic low);
        return low ? ~v : v;
    endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: frame-input and display-output bundle of the scan driver.
// Signals: en (scan enable), load (accept frame), digits_in (4 bits per digit, [3:0]=LSD),
// dp_in (decimal points), seg (a..g at [0]..[6]), dp, an (one-hot digit enable), frame_done.
// master drives the frame side, slave is the driver itself.
interface seg_scan_driver_if #(parameter int DIGITS = 4);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;
    modport master (output en, load, digits_in, dp_in, input seg, dp, an, frame_done);
    modport slave (input en, load, digits_in, dp_in, output seg, dp, an, frame_done);
endinterface

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational 4-bit code to active-high seven-segment glyph.
// Ports: code (in, 4), glyph (out, 7, bit order g..a). Codes 10-15 are blank unless HEX_MODE=1.
module seg_glyph_rom import seg_pkg::*; #(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] code,
    output logic [6:0] glyph
);
    always_comb glyph = (HEX_MODE == 0 && code > 4'd9) ? 7'h00 : GLYPHS[code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment driver with tear-free frame update.
// Ports: clk, rst (sync, active-high), bus (seg_scan_driver_if.slave: en, load, digits_in,
// dp_in in; seg, dp, an, frame_done out, all registered).
module seg_scan_driver import seg_pkg::*; #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1000,
    parameter int HEX_MODE       = 1,
    parameter int BLANK_LEAD     = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);
    localparam int IDX_W = clog2_min1(DIGITS);
    localparam int PRE_W = clog2_min1(CLK_DIV);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0]  LAST_PRE = PRE_W'(CLK_DIV - 1);
    localparam logic              SEG_LOW  = SEG_ACTIVE_LOW != 0;
    localparam logic              AN_LOW   = AN_ACTIVE_LOW != 0;
    localparam logic [6:0]        SEG_OFF  = 7'(apply_pol(8'h00, SEG_LOW));
    localparam logic [DIGITS-1:0] AN_OFF   = DIGITS'(apply_pol(8'h00, AN_LOW));

    logic [PRE_W-1:0]             prescaler;
    logic [IDX_W-1:0]             idx;
    logic [DIGITS-1:0][3:0]       disp_d, stage_d;
    logic [DIGITS-1:0]            disp_p, stage_p;
    logic                         pending;
    logic                         tick, wrap;
    logic [DIGITS-1:0]            blank, onehot;
    logic                         lead_zero;
    logic [3:0]                   code;
    logic                         cur_dp, cur_blank;
    logic [6:0]                   glyph;

    assign tick = bus.en && prescaler == LAST_PRE;
    assign wrap = tick && idx == LAST_IDX;

    // Walk from the MSD down; a digit is blanked while everything at or above it is zero.
    always_comb begin
        blank = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero && disp_d[i] == 4'd0;
            blank[i] = BLANK_LEAD != 0 && lead_zero;
        end
    end

    always_comb begin
        code = '0;
        cur_dp = 1'b0;
        cur_blank = 1'b0;
        onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                code = disp_d[i];
                cur_dp = disp_p[i];
                cur_blank = blank[i];
                onehot[i] = 1'b1;
            end
        end
    end

    seg_glyph_rom #(.HEX_MODE(HEX_MODE)) u_rom (.code(code), .glyph(glyph));

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx <= '0;
            disp_d <= '0;
            disp_p <= '0;
            stage_d <= '0;
            stage_p <= '0;
            pending <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.seg <= SEG_OFF;
            bus.dp <= SEG_LOW;
            bus.an <= AN_OFF;
        end else begin
            if (bus.en) prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;
            bus.frame_done <= wrap;
            // A load coinciding with the frame boundary bypasses staging entirely.
            if (wrap && bus.load) begin
                disp_d <= bus.digits_in;
                disp_p <= bus.dp_in;
                pending <= 1'b0;
            end else if (wrap && pending) begin
                disp_d <= stage_d;
                disp_p <= stage_p;
                pending <= 1'b0;
            end else if (bus.load) begin
                stage_d <= bus.digits_in;
                stage_p <= bus.dp_in;
                pending <= 1'b1;
            end
            bus.seg <= bus.en ? 7'(apply_pol({1'b0, cur_blank ? 7'h00 : glyph}, SEG_LOW)) : SEG_OFF;
            bus.dp <= bus.en ? cur_dp ^ SEG_LOW : SEG_LOW;
            bus.an <= bus.en ? DIGITS'(apply_pol(8'(onehot), AN_LOW)) : AN_OFF;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver.
// Instances: ua (4 digits, hex, blanking), ub (HEX_MODE=0), uc (BLANK_LEAD=0) share ua's inputs;
// u1 (1 digit) and u8 (8 digits) use inverted polarities. All use CLK_DIV=4.
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;

    localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011, G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110, G5 = 7'b1101101, G6 = 7'b1111101, G7 = 7'b0000111;
    localparam logic [6:0] G8 = 7'b1111111, G9 = 7'b1101111, GA = 7'b1110111;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(4)) ia ();
    seg_scan_driver_if #(.DIGITS(4)) ib ();
    seg_scan_driver_if #(.DIGITS(4)) ic ();
    seg_scan_driver_if #(.DIGITS(1)) i1 ();
    seg_scan_driver_if #(.DIGITS(8)) i8 ();

    seg_scan_driver #(.DIGITS(4), .CLK_DIV(4)) ua (.clk(clk), .rst(rst), .bus(ia));
    seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0)) ub (.clk(clk), .rst(rst), .bus(ib));
    seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLANK_LEAD(0)) uc (.clk(clk), .rst(rst), .bus(ic));
    seg_scan_driver #(.DIGITS(1), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u1 (.clk(clk), .rst(rst), .bus(i1));
    seg_scan_driver #(.DIGITS(8), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u8 (.clk(clk), .rst(rst), .bus(i8));

    assign ib.en = ia.en;
    assign ib.load = ia.load;
    assign ib.digits_in = ia.digits_in;
    assign ib.dp_in = ia.dp_in;
    assign ic.en = ia.en;
    assign ic.load = ia.load;
    assign ic.digits_in = ia.digits_in;
    assign ic.dp_in = ia.dp_in;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame();
        step(1);
        for (int k = 0; k < 100 && !ia.frame_done; k++) step(1);
        tests++;
        if (ia.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL wait_frame: frame_done got %b exp 1 within 100 cycles", ia.frame_done);
        end
    endtask

    task automatic load_frame(input logic [15:0] d, input logic [3:0] p);
        ia.digits_in = d;
        ia.dp_in = p;
        ia.load = 1'b1;
        step(1);
        ia.load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1);
        tests++;
        if (ia.an !== 4'b1111 || ia.seg !== 7'h00 || ia.frame_done !== 1'b0) begin
            failed++;
            $display("FAIL reset_outputs: an=%b seg=%b fd=%b exp 1111 0000000 0", ia.an, ia.seg, ia.frame_done);
        end
        step(2);
        rst = 1'b0;
        step(1);
        tests++;
        if (ia.an !== 4'b1110 || ia.seg !== G0) begin
            failed++;
            $display("FAIL release_digit0: an=%b seg=%b exp 1110 %b", ia.an, ia.seg, G0);
        end
        step(3);
        tests++;
        if (ia.an !== 4'b1110) begin
            failed++;
            $display("FAIL prescale_hold: an=%b exp 1110", ia.an);
        end
        step(1);
        tests++;
        if (ia.an !== 4'b1101 || ia.seg !== 7'h00) begin
            failed++;
            $display("FAIL first_advance: an=%b seg=%b exp 1101 0000000", ia.an, ia.seg);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ean [4];
        logic [6:0] eseg [4];
        ean = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        eseg = '{G1, G2, G3, G4};
        load_frame(16'h4321, 4'b0010);
        wait_frame();
        for (int i = 0; i < 4; i++) begin
            step(1);
            tests++;
            if (ia.an !== ean[i] || ia.seg !== eseg[i] || ia.dp !== (i == 1) || ia.frame_done !== 1'b0) begin
                failed++;
                $display("FAIL scan_digit%0d: an=%b seg=%b dp=%b fd=%b exp %b %b %b 0",
                         i, ia.an, ia.seg, ia.dp, ia.frame_done, ean[i], eseg[i], i == 1);
            end
            step(3);
        end
        tests++;
        if (ia.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL scan_frame_done: got %b exp 1", ia.frame_done);
        end
    endtask

    task automatic test_tear_free();
        wait_frame();
        step(8);
        load_frame(16'h9999, 4'b0000);
        tests++;
        if (ia.an !== 4'b1011 || ia.seg !== G3) begin
            failed++;
            $display("FAIL tear_digit2_old: an=%b seg=%b exp 1011 %b", ia.an, ia.seg, G3);
        end
        step(4);
        tests++;
        if (ia.an !== 4'b0111 || ia.seg !== G4) begin
            failed++;
            $display("FAIL tear_digit3_old: an=%b seg=%b exp 0111 %b", ia.an, ia.seg, G4);
        end
        step(4);
        tests++;
        if (ia.an !== 4'b1110 || ia.seg !== G9) begin
            failed++;
            $display("FAIL tear_next_frame: an=%b seg=%b exp 1110 %b", ia.an, ia.seg, G9);
        end
        step(4);
        tests++;
        if (ia.an !== 4'b1101 || ia.seg !== G9) begin
            failed++;
            $display("FAIL tear_next_digit1: an=%b seg=%b exp 1101 %b", ia.an, ia.seg, G9);
        end
        step(10);
        load_frame(16'h5678, 4'b0000);
        tests++;
        if (ia.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL wrap_load_edge: frame_done=%b exp 1", ia.frame_done);
        end
        step(1);
        tests++;
        if (ia.seg !== G8) begin
            failed++;
            $display("FAIL wrap_load_digit0: seg=%b exp %b", ia.seg, G8);
        end
        step(4);
        tests++;
        if (ia.seg !== G7) begin
            failed++;
            $display("FAIL wrap_load_digit1: seg=%b exp %b", ia.seg, G7);
        end
    endtask

    task automatic test_blank_hex();
        logic [6:0] ea [4];
        logic [6:0] eb [4];
        logic [6:0] ec [4];
        logic [3:0] ean [4];
        ea = '{G0, GA, 7'h00, 7'h00};
        eb = '{G0, 7'h00, 7'h00, 7'h00};
        ec = '{G0, GA, G0, G0};
        ean = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        load_frame(16'h00A0, 4'b0000);
        wait_frame();
        for (int i = 0; i < 4; i++) begin
            step(1);
            tests++;
            if (ia.seg !== ea[i] || ia.an !== ean[i]) begin
                failed++;
                $display("FAIL blank_hex_digit%0d: seg=%b an=%b exp %b %b", i, ia.seg, ia.an, ea[i], ean[i]);
            end
            tests++;
            if (ib.seg !== eb[i]) begin
                failed++;
                $display("FAIL nohex_digit%0d: seg=%b exp %b", i, ib.seg, eb[i]);
            end
            tests++;
            if (ic.seg !== ec[i]) begin
                failed++;
                $display("FAIL noblank_digit%0d: seg=%b exp %b", i, ic.seg, ec[i]);
            end
            step(3);
        end
    endtask

    task automatic test_enable_reset();
        wait_frame();
        step(5);
        tests++;
        if (ia.an !== 4'b1101) begin
            failed++;
            $display("FAIL en_pre_digit1: an=%b exp 1101", ia.an);
        end
        ia.en = 1'b0;
        step(1);
        tests++;
        if (ia.an !== 4'b1111 || ia.seg !== 7'h00 || ia.dp !== 1'b0) begin
            failed++;
            $display("FAIL en_off: an=%b seg=%b dp=%b exp 1111 0000000 0", ia.an, ia.seg, ia.dp);
        end
        step(8);
        tests++;
        if (ia.an !== 4'b1111 || ia.frame_done !== 1'b0) begin
            failed++;
            $display("FAIL en_off_hold: an=%b fd=%b exp 1111 0", ia.an, ia.frame_done);
        end
        ia.en = 1'b1;
        step(1);
        tests++;
        if (ia.an !== 4'b1101) begin
            failed++;
            $display("FAIL en_resume: an=%b exp 1101", ia.an);
        end
        step(2);
        tests++;
        if (ia.an !== 4'b1101) begin
            failed++;
            $display("FAIL en_resume_hold: an=%b exp 1101", ia.an);
        end
        step(1);
        tests++;
        if (ia.an !== 4'b1011) begin
            failed++;
            $display("FAIL en_prescaler_kept: an=%b exp 1011", ia.an);
        end
        load_frame(16'h1111, 4'b1111);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tests++;
        if (ia.an !== 4'b1111 || ia.seg !== 7'h00) begin
            failed++;
            $display("FAIL midreset_outputs: an=%b seg=%b exp 1111 0000000", ia.an, ia.seg);
        end
        wait_frame();
        step(1);
        tests++;
        if (ia.seg !== G0 || ia.dp !== 1'b0) begin
            failed++;
            $display("FAIL midreset_discard_d0: seg=%b dp=%b exp %b 0", ia.seg, ia.dp, G0);
        end
        step(4);
        tests++;
        if (ia.an !== 4'b1101 || ia.seg !== 7'h00 || ia.dp !== 1'b0) begin
            failed++;
            $display("FAIL midreset_discard_d1: an=%b seg=%b dp=%b exp 1101 0000000 0", ia.an, ia.seg, ia.dp);
        end
    endtask

    task automatic test_param();
        rst = 1'b1;
        i1.en = 1'b1;
        i8.en = 1'b1;
        i1.digits_in = 4'h5;
        i8.digits_in = 32'h87654321;
        step(1);
        tests++;
        if (i1.an !== 1'b0 || i1.seg !== 7'h7F || i8.an !== 8'h00 || i8.dp !== 1'b1) begin
            failed++;
            $display("FAIL param_reset: an1=%b seg1=%b an8=%b dp8=%b exp 0 1111111 00000000 1", i1.an, i1.seg, i8.an, i8.dp);
        end
        rst = 1'b0;
        i1.load = 1'b1;
        i8.load = 1'b1;
        step(1);
        i1.load = 1'b0;
        i8.load = 1'b0;
        step(3);
        tests++;
        if (i1.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL d1_first_wrap: fd=%b exp 1", i1.frame_done);
        end
        step(1);
        tests++;
        if (i1.frame_done !== 1'b0 || i1.seg !== ~G5 || i1.an !== 1'b1) begin
            failed++;
            $display("FAIL d1_digit: fd=%b seg=%b an=%b exp 0 %b 1", i1.frame_done, i1.seg, i1.an, ~G5);
        end
        step(3);
        tests++;
        if (i1.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL d1_every_tick: fd=%b exp 1", i1.frame_done);
        end
        for (int k = 0; k < 100 && !i8.frame_done; k++) step(1);
        tests++;
        if (i8.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL d8_wrap_timeout: fd=%b exp 1", i8.frame_done);
        end
        step(1);
        tests++;
        if (i8.an !== 8'h01 || i8.seg !== ~G1 || i8.dp !== 1'b1) begin
            failed++;
            $display("FAIL d8_digit0: an=%b seg=%b dp=%b exp 00000001 %b 1", i8.an, i8.seg, i8.dp, ~G1);
        end
        step(28);
        tests++;
        if (i8.an !== 8'h80 || i8.seg !== ~G8) begin
            failed++;
            $display("FAIL d8_digit7: an=%b seg=%b exp 10000000 %b", i8.an, i8.seg, ~G8);
        end
        step(3);
        tests++;
        if (i8.frame_done !== 1'b1) begin
            failed++;
            $display("FAIL d8_period: fd=%b exp 1", i8.frame_done);
        end
    endtask

    initial begin
        ia.en = 1'b1;
        ia.load = 1'b0;
        ia.digits_in = '0;
        ia.dp_in = '0;
        i1.en = 1'b0;
        i1.load = 1'b0;
        i1.digits_in = '0;
        i1.dp_in = '0;
        i8.en = 1'b0;
        i8.load = 1'b0;
        i8.digits_in = '0;
        i8.dp_in = '0;
        test_reset();
        test_scan();
        test_tear_free();
        test_blank_hex();
        test_enable_reset();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
